piso_serializer8: RTL

- Byte-wide parallel-in, serial-out stage that sits directly upstream of the 8:1 bit-select mux.
- Accepts one byte per valid/ready handshake and latches it into a hold register.
- Drives the mux select through a 3-bit bit index, then emits the byte one bit at a time on sout.
- Each bit is held for a programmable number of clock cycles, with a valid flag and an end-of-frame pulse.

---
 rtl/piso_serializer8_pkg.sv | 21 ++
 rtl/piso_serializer8_if.sv | 26 ++
 rtl/piso_serializer8_mux8_1.sv | 10 +
 rtl/piso_serializer8.sv | 81 ++++++++
 4 files changed

// File: rtl/piso_serializer8_pkg.sv
// Shared types and constants for the byte-wide parallel-in, serial-out stage.
package piso_serializer8_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit index of the first bit of a frame.
  function automatic logic [2:0] first_sel(input bit lsb_first);
    return lsb_first ? 3'd0 : 3'd7;
  endfunction

  // Bit index of the next bit of a frame.
  function automatic logic [2:0] step_sel(input logic [2:0] sel, input bit lsb_first);
    return lsb_first ? sel + 3'd1 : sel - 3'd1;
  endfunction

endpackage

// File: rtl/piso_serializer8_if.sv
// Byte input handshake and serial output bundle of the serializer.
// din_valid/din_ready: a byte moves on a rising edge where both are high; the
// producer keeps din and din_valid stable until that edge.
interface piso_serializer8_if;
  import piso_serializer8_pkg::*;

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              sout;
  logic              sout_valid;
  logic [2:0]        sel;
  logic              done;
  state_t            state;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sel, done, state
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sel, done, state
  );

endinterface

// File: rtl/piso_serializer8_mux8_1.sv
// 8:1 bit-select mux driven by the serializer's bit index.
module mux8_1 (
  input  logic [7:0] i,
  input  logic [2:0] sel,
  output logic       q
);

  assign q = i[sel];

endmodule

// File: rtl/piso_serializer8.sv
// Latches one byte per handshake and shifts it out on sout, holding each bit
// for CLKS_PER_BIT cycles.
module piso_serializer8
  import piso_serializer8_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer8_if.slave  bus
);

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("piso_serializer8: CLKS_PER_BIT must be >= 1");
  end

  localparam int             TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(CLKS_PER_BIT - 1);

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [2:0]        sel;
  logic [2:0]        bit_cnt;
  logic [TW-1:0]     tick_cnt;
  logic              raw_bit;
  logic              last_tick;

  assign last_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      sel      <= '0;
      bit_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            hold     <= bus.din;
            sel      <= first_sel(LSB_FIRST);
            bit_cnt  <= '0;
            tick_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_tick) begin
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            // sel parks on the final index instead of wrapping past it.
            if (bit_cnt == 3'd7) begin
              state <= IDLE;
            end else begin
              sel <= step_sel(sel, LSB_FIRST);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mux8_1 u_mux (
    .i   (hold),
    .sel (sel),
    .q   (raw_bit)
  );

  assign bus.din_ready  = (state == IDLE);
  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout       = raw_bit & (state == SHIFT);
  assign bus.sel        = sel;
  assign bus.done       = (state == SHIFT) && (bit_cnt == 3'd7) && last_tick;
  assign bus.state      = state;

endmodule
